fixed_to_floating_conversion: RTL

Converts an unsigned fixed-point Q(INTEGER).(FRACTION) word into an IEEE-754 single-precision float. It is the return-path stage of the softmax/exponential datapath, placed after the fixed-point arithmetic that consumes the float-to-fixed converter's output. Normalisation is iterative: one left shift per clock until the leading one reaches the MSB. The start/ready handshake matches the float-to-fixed converter.

---
 rtl/fixed_to_floating_conversion_pkg.sv | 23 ++
 rtl/fixed_to_floating_conversion.sv | 92 +++++++++
 2 files changed

// File: rtl/fixed_to_floating_conversion_pkg.sv
// Shared constants for the fixed<->float conversion stages of the softmax datapath.
package fixed_to_floating_conversion_pkg;

  // Default number format, shared with floating_to_fixed_conversion
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_M          = 23;
  localparam int unsigned DEF_E          = 8;
  localparam int unsigned DEF_BIAS       = 2 ** (DEF_E - 1) - 1;
  localparam int unsigned DEF_INTEGER    = 10;
  localparam int unsigned DEF_FRACTION   = 22;

  // Converter FSM encoding (1-bit state register)
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] NORMALIZE = 1'b1;

  // Single-precision field positions for the default format
  localparam int unsigned SIGN_POS = DEF_DATA_WIDTH - 1;
  localparam int unsigned EXP_MSB  = DEF_DATA_WIDTH - 2;
  localparam int unsigned EXP_LSB  = DEF_M;
  localparam int unsigned MANT_MSB = DEF_M - 1;
  localparam int unsigned MANT_LSB = 0;

endpackage

// File: rtl/fixed_to_floating_conversion.sv
// Unsigned fixed-point to single-precision float, normalising one bit per clock.
module fixed_to_floating_conversion
  import fixed_to_floating_conversion_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned M          = DEF_M,
  parameter int unsigned E          = DEF_E,
  parameter int unsigned BIAS       = DEF_BIAS,
  parameter int unsigned FRACTION   = DEF_FRACTION
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fixed_point_input,
  input  logic                  start_fixed_to_floating_conversion,
  output logic [DATA_WIDTH-1:0] floating_point_output,
  output logic                  floating_point_number_ready,
  output logic                  busy
);

  localparam int unsigned CW         = $clog2(DATA_WIDTH);
  // Exponent of an input whose leading one already sits at the MSB
  localparam int unsigned EXP_AT_MSB = BIAS + DATA_WIDTH - 1 - FRACTION;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  ready_q, ready_d;
  logic [E-1:0]          exp_c;
  logic [M-1:0]          mant_c;

  // Exponent falls by one per normalising shift; mantissa drops the hidden one
  always_comb begin
    exp_c  = E'((E+1)'(EXP_AT_MSB) - (E+1)'(count_q));
    mant_c = shift_q[DATA_WIDTH-2 -: M];
  end

  // Next-state, datapath and completion logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    out_d   = out_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_fixed_to_floating_conversion) begin
          shift_d = fixed_point_input;
          count_d = '0;
          state_d = NORMALIZE;
        end
      end
      NORMALIZE: begin
        if (shift_q == '0) begin
          out_d   = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (shift_q[DATA_WIDTH-1]) begin
          out_d   = {1'b0, exp_c, mant_c};
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          shift_d = shift_q << 1;
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign floating_point_output       = out_q;
  assign floating_point_number_ready = ready_q;
  assign busy                        = (state_q == NORMALIZE);

endmodule
